// File: rtl/pwm_writer_8ch.sv
// pwm_writer_8ch: eight-channel RC/servo PWM generator behind an AXI4-Lite
// register file; widths and period are double-buffered per frame.
module pwm_writer_8ch #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int CLK_DIV            = 100,
  parameter int RST_WIDTH          = 1500,
  parameter int RST_PERIOD         = 20000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [7:0]                      pwm_out
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [15:0] W_RST = 16'(RST_WIDTH);
  localparam logic [15:0] P_RST = 16'(RST_PERIOD);

  // live registers
  logic [15:0] width [8];
  logic [15:0] period;
  logic        en;
  logic [7:0]  mask;

  // per-frame shadows and timebase
  logic [15:0]   sh_width [8];
  logic [15:0]   sh_period;
  logic [PW-1:0] presc;
  logic [15:0]   cnt;
  logic [15:0]   frames;
  logic          en_d;
  logic          tick;
  logic          start;
  logic          wrap;

  // bus side
  logic        awready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        arready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic        wr_fire;
  logic        rd_fire;
  int unsigned wi;
  int unsigned ri;
  logic [7:0]  sel_w;
  logic        sel_p;
  logic        sel_c;
  logic        wr_err;
  logic [15:0] wd;
  logic [1:0]  ws;
  logic [15:0] p_new;
  logic [15:0] p_st;
  logic [15:0] c_new;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic        rd_err;
  logic        unused_bits;

  function automatic logic [15:0] merge(
    input logic [15:0] old,
    input logic [15:0] d,
    input logic [1:0]  s
  );
    merge = {s[1] ? d[15:8] : old[15:8],
             s[0] ? d[7:0]  : old[7:0]};
  endfunction

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = awready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;

  assign wr_fire = awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready & S_AXI_ARVALID;

  assign wi = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ri = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign wd = S_AXI_WDATA[15:0];
  assign ws = S_AXI_WSTRB[1:0];

  assign p_new = merge(period, wd, ws);
  assign p_st  = (p_new < 16'd2) ? 16'd2 : p_new;
  assign c_new = merge({mask, 7'd0, en}, wd, ws);

  assign unused_bits = ^{S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:16],
                         S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:2],
                         S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0]};

  // decode the write address into a register select or a slave error
  always_comb begin
    sel_w  = '0;
    sel_p  = 1'b0;
    sel_c  = 1'b0;
    wr_err = 1'b0;
    unique case (1'b1)
      (wi < 32'd8):   sel_w[wi[2:0]] = 1'b1;
      (wi == 32'd8):  sel_p = 1'b1;
      (wi == 32'd9):  sel_c = 1'b1;
      (wi == 32'd10): ;
      default:        wr_err = 1'b1;
    endcase
  end

  // select read data; unmapped addresses return zero with an error
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      (ri < 32'd8):
        rd_word = C_S_AXI_DATA_WIDTH'(width[ri[2:0]]);
      (ri == 32'd8):
        rd_word = C_S_AXI_DATA_WIDTH'(period);
      (ri == 32'd9):
        rd_word = C_S_AXI_DATA_WIDTH'({mask, 7'd0, en});
      (ri == 32'd10):
        rd_word = C_S_AXI_DATA_WIDTH'({frames, cnt});
      default:
        rd_err = 1'b1;
    endcase
  end

  // live register file, byte-strobed
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 8; i++) width[i] <= W_RST;
      period <= P_RST;
      en     <= 1'b0;
      mask   <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < 8; i++)
        if (sel_w[i]) width[i] <= merge(width[i], wd, ws);
      if (sel_p) period <= p_st;
      if (sel_c) begin
        en   <= c_new[0];
        mask <= c_new[15:8];
      end
    end
  end

  // write channel: joint AW/W accept, single outstanding response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      awready <= S_AXI_AWVALID & S_AXI_WVALID &
                 ~bvalid & ~awready;
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= wr_err ? SLVERR : OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // read channel: data captured at accept, held until taken
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= OKAY;
      rdata   <= '0;
    end else begin
      arready <= S_AXI_ARVALID & ~rvalid & ~arready;
      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
        rresp  <= rd_err ? SLVERR : OKAY;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign start = en & ~en_d;
  assign tick  = en & (presc == PMAX);
  assign wrap  = tick & (cnt >= sh_period - 16'd1);

  // prescaler, frame counter and shadow reload at frame boundaries
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en_d      <= 1'b0;
      presc     <= '0;
      cnt       <= '0;
      frames    <= '0;
      sh_period <= P_RST;
      for (int i = 0; i < 8; i++) sh_width[i] <= W_RST;
    end else begin
      en_d <= en;
      if (!en) begin
        presc <= '0;
        cnt   <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (start || wrap) begin
          cnt       <= '0;
          sh_period <= period;
          for (int i = 0; i < 8; i++) sh_width[i] <= width[i];
          if (wrap) frames <= frames + 16'd1;
        end else if (tick) begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

  // outputs compare against the widths the current frame runs with
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        pwm_out[i] <= en & mask[i] &
          (cnt < (start ? width[i] : sh_width[i]));
    end
  end

endmodule

// File: tb/tb_pwm_writer_8ch.sv
// tb_pwm_writer_8ch: scoreboard bench for the 8-channel PWM writer
// with a register model and a channel-0 pulse-length monitor.
module tb_pwm_writer_8ch;

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  pwm_out;

  always #5 clk = ~clk;

  pwm_writer_8ch #(.CLK_DIV(4)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] mdl [10];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  int          pq [$];
  int          pulses [$];
  logic        mon_on = 1'b0;
  int          run = 0;

  always @(posedge clk) cyc++;

  // channel-0 high-pulse lengths in ACLK cycles
  always @(negedge clk) begin
    if (!mon_on) run = 0;
    else if (pwm_out[0]) run++;
    else if (run != 0) begin
      pulses.push_back(run);
      run = 0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bmerge(
    input logic [15:0] o, input logic [31:0] d,
    input logic [3:0] s);
    return {s[1] ? d[15:8] : o[15:8], s[0] ? d[7:0] : o[7:0]};
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h05DC;
    mdl[8] = 16'h4E20;
    mdl[9] = 16'h0000;
  endtask

  function automatic logic [1:0] mdl_write(
    input logic [5:0] a, input logic [31:0] d,
    input logic [3:0] s);
    logic [15:0] v;
    int i;
    i = int'(a[5:2]);
    if (i < 8) begin
      mdl[i] = bmerge(mdl[i], d, s);
      return OKAY;
    end
    if (i == 8) begin
      v = bmerge(mdl[8], d, s);
      mdl[8] = (v < 16'd2) ? 16'd2 : v;
      return OKAY;
    end
    if (i == 9) begin
      mdl[9] = bmerge(mdl[9], d, s) & 16'hFF01;
      return OKAY;
    end
    if (i == 10) return OKAY;
    return SLVERR;
  endfunction

  task automatic wr_start(input logic [5:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(mdl_write(a, d, s));
  endtask

  task automatic wr_wait_acc();
    int n = 0;
    while (!(awready && wready) && n < 50) begin
      @(negedge clk); n++;
    end
    check("aw_accept", 32'(n < 50), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wr_wait_resp();
    int n = 0;
    logic [1:0] e;
    bready = 1'b1;
    while (!bvalid && n < 50) begin
      @(negedge clk); n++;
    end
    e = bq.pop_front();
    check("b_seen", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(e));
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    wr_start(a, d, s);
    wr_wait_acc();
    wr_wait_resp();
  endtask

  task automatic rd_raw(input logic [5:0] a,
                        output logic [31:0] d,
                        output logic [1:0] r);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk); n++;
    end
    check("ar_accept", 32'(n < 50), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk); n++;
    end
    check("r_seen", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a,
                    input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    rq.push_back({er, ed});
    rd_raw(a, d, r);
    e = rq.pop_front();
    check({tag, "_data"}, d, e[31:0]);
    check({tag, "_resp"}, 32'(r), 32'(e[33:32]));
  endtask

  task automatic rd_model();
    for (int i = 0; i < 10; i++)
      rd($sformatf("reg%0d", i), 6'(4 * i), 32'(mdl[i]), OKAY);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] s0;
    logic [1:0]  r0;
    int c0;
    int n;
    int hi [8];
    int g;
    int e;

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0;
    arvalid = 1'b0; rready = 1'b0;
    mdl_reset();
    repeat (4) @(negedge clk);
    check("rst_io", 32'({awready, wready, bvalid, arready,
                         rvalid, bresp, rresp, pwm_out}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    rd_model();
    rd("status_rst", 6'h28, 32'd0, OKAY);
    check("pwm_rst", 32'(pwm_out), 32'd0);

    // basic frame: CLK_DIV=4, period 10
    wr(6'h20, 32'd10, 4'hF);
    wr(6'h00, 32'd3, 4'hF);
    wr(6'h1C, 32'd10, 4'hF);
    wr(6'h24, 32'h8101, 4'hF);
    rd("ctrl", 6'h24, 32'h8101, OKAY);
    repeat (100) @(negedge clk);
    for (int i = 0; i < 8; i++) hi[i] = 0;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (pwm_out[i]) hi[i]++;
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("hi_ch%0d", i), 32'(hi[i]),
            (i == 0) ? 32'd12 : (i == 7) ? 32'd40 : 32'd0);

    // frame count advances by exactly 2 every 80 ACLK
    c0 = cyc;
    rd_raw(6'h28, s0, r0);
    while (cyc < c0 + 80) @(negedge clk);
    rd("status_adv", 6'h28, s0 + 32'h0002_0000, OKAY);

    // mid-frame width change waits for the frame boundary
    n = 0;
    while (pwm_out[0] && n < 100) begin @(negedge clk); n++; end
    pulses.delete();
    mon_on = 1'b1;
    n = 0;
    while (!pwm_out[0] && n < 100) begin @(negedge clk); n++; end
    check("rise_seen", 32'(pwm_out[0]), 32'd1);
    wr(6'h00, 32'd7, 4'hF);
    pq.push_back(12);
    pq.push_back(28);
    pq.push_back(28);
    n = 0;
    while (pulses.size() < 3 && n < 400) begin
      @(negedge clk); n++;
    end
    check("pulse_cnt", 32'(pulses.size() >= 3), 32'd1);
    while (pq.size() != 0) begin
      e = pq.pop_front();
      g = (pulses.size() != 0) ? pulses.pop_front() : -1;
      check("pulse_len", 32'(g), 32'(e));
    end
    mon_on = 1'b0;

    // period floor and byte strobes
    wr(6'h20, 32'd0, 4'hF);
    rd("per_min", 6'h20, 32'd2, OKAY);
    wr(6'h04, 32'h0000_FFFF, 4'b0001);
    rd("w1_strb", 6'h04, 32'h0000_05FF, OKAY);

    // unmapped addresses
    wr(6'h30, 32'hDEAD_BEEF, 4'hF);
    rd("bad", 6'h3C, 32'd0, SLVERR);

    // held response blocks a second write
    wr_start(6'h34, 32'h1234, 4'hF);
    wr_wait_acc();
    wr_start(6'h28, 32'hFFFF, 4'hF);
    repeat (5) begin
      @(negedge clk);
      check("b_hold", 32'(bvalid), 32'd1);
      check("no_aw", 32'(awready), 32'd0);
    end
    wr_wait_resp();
    wr_wait_acc();
    wr_wait_resp();
    rd_model();

    // reset mid-pulse with a pending response
    n = 0;
    while (!pwm_out[0] && n < 100) begin @(negedge clk); n++; end
    check("pre_rst_hi", 32'(pwm_out[0]), 32'd1);
    wr_start(6'h08, 32'h55, 4'hF);
    wr_wait_acc();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    rst = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0;
    bq.delete();
    mdl_reset();
    rd("ctrl_rst", 6'h24, 32'd0, OKAY);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (pwm_out != 8'd0) n++;
    end
    check("quiet", 32'(n), 32'd0);
    rd_model();
    rd("status_rst2", 6'h28, 32'd0, OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
